// File: rtl/phase_sequencer.sv
// Phase sequencer: drives the one-hot pipeline-register load strobes and
// handles run/pause, single-step, HLT and hazard stalls.
module phase_sequencer #(
  parameter int NPHASE = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              exec,
  input  logic              step,
  input  logic              halt_req,
  input  logic              stall,
  output logic [NPHASE-1:0] phasecounter,
  output logic              running,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count
);

  localparam int PW = (NPHASE > 1) ? $clog2(NPHASE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(NPHASE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_STEP   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NPHASE-1:0] phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              halt_pend_q, halt_pend_d;
  logic              pause_pend_q, pause_pend_d;
  logic              exec_d_q, step_d_q;

  logic exec_rise, step_rise, active, boundary;

  assign exec_rise = exec & ~exec_d_q;
  assign step_rise = step & ~step_d_q;
  assign active    = (state_q == S_RUN) || (state_q == S_STEP);
  // The last phase is issued on this edge, so the instruction completes here.
  assign boundary  = active && !stall && (ptr_q == PLAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      phase_q      <= '0;
      cnt_q        <= '0;
      halt_pend_q  <= 1'b0;
      pause_pend_q <= 1'b0;
      exec_d_q     <= 1'b0;
      step_d_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      halt_pend_q  <= halt_pend_d;
      pause_pend_q <= pause_pend_d;
      exec_d_q     <= exec;
      step_d_q     <= step;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    phase_d      = '0;
    cnt_d        = cnt_q;
    halt_pend_d  = halt_pend_q;
    pause_pend_d = pause_pend_q;

    unique case (state_q)
      S_IDLE: begin
        if (exec_rise)      state_d = S_RUN;
        else if (step_rise) state_d = S_STEP;
      end
      S_RUN, S_STEP: begin
        if (halt_req)                        halt_pend_d  = 1'b1;
        if (exec_rise && state_q == S_RUN)   pause_pend_d = 1'b1;
        if (!stall) begin
          phase_d = NPHASE'(1) << ptr_q;
          ptr_d   = (ptr_q == PLAST) ? '0 : ptr_q + PW'(1);
        end
        if (boundary) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (halt_pend_d)
            state_d = S_HALTED;
          else if (pause_pend_d || state_q == S_STEP)
            state_d = S_IDLE;
          halt_pend_d  = 1'b0;
          pause_pend_d = 1'b0;
        end
      end
      S_HALTED: ;
      default: state_d = S_IDLE;
    endcase
  end

  assign phasecounter = phase_q;
  assign instr_count  = cnt_q;
  assign running      = (state_q == S_RUN) || (state_q == S_STEP);
  assign halted       = (state_q == S_HALTED);

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed scenarios with literal expectations plus
// a long random run checked every cycle against a behavioural model.
module tb_phase_sequencer;
  localparam int NPHASE = 5;
  localparam int CNT_W  = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic exec = 1'b0, step = 1'b0, halt_req = 1'b0, stall = 1'b0;
  logic [NPHASE-1:0] phasecounter;
  logic running, halted;
  logic [CNT_W-1:0] instr_count;

  int n_cmp = 0;
  int n_bad = 0;

  phase_sequencer #(.NPHASE(NPHASE), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .exec(exec), .step(step),
    .halt_req(halt_req), .stall(stall), .phasecounter(phasecounter),
    .running(running), .halted(halted), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  // Model: mode 0 idle, 1 free-running, 2 single instruction, 3 halted.
  // pos = phases already issued in the current instruction.
  typedef struct packed {
    logic [1:0]  mode;
    logic [2:0]  pos;
    logic [15:0] cnt;
    logic        hp, pp, pe, ps;
    logic [4:0]  pc;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t nxt(mdl_t c, logic ex, logic st, logic hr, logic sl);
    mdl_t n;
    logic er, sr;
    n  = c;
    er = ex & ~c.pe;
    sr = st & ~c.ps;
    n.pe = ex;
    n.ps = st;
    n.pc = '0;
    if (c.mode == 2'd0) begin
      if (er)      n.mode = 2'd1;
      else if (sr) n.mode = 2'd2;
    end else if (c.mode != 2'd3) begin
      if (hr) n.hp = 1'b1;
      if (er && c.mode == 2'd1) n.pp = 1'b1;
      if (!sl) begin
        n.pc = 5'd1 << c.pos;
        if (int'(c.pos) == NPHASE - 1) begin
          n.pos = 3'd0;
          n.cnt = c.cnt + 16'd1;
          if (n.hp)                       n.mode = 2'd3;
          else if (n.pp || c.mode == 2'd2) n.mode = 2'd0;
          n.hp = 1'b0;
          n.pp = 1'b0;
        end else begin
          n.pos = c.pos + 3'd1;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) m <= '0;
    else       m <= nxt(m, exec, step, halt_req, stall);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        chk("mdl_pc", 32'(phasecounter), 32'(m.pc));
        chk("mdl_running", 32'(running), 32'(m.mode == 2'd1 || m.mode == 2'd2));
        chk("mdl_halted", 32'(halted), 32'(m.mode == 2'd3));
        chk("mdl_count", 32'(instr_count), 32'(m.cnt));
      end
    end
  end

  // Apply inputs for one edge; outputs are then read at the following negedge.
  task automatic cyc(input logic ex, input logic st, input logic hr, input logic sl);
    exec = ex; step = st; halt_req = hr; stall = sl;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic cpc(input logic ex, input logic st, input logic hr, input logic sl,
                     input logic [4:0] exp, input string nm);
    cyc(ex, st, hr, sl);
    chk(nm, 32'(phasecounter), 32'(exp));
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    exec = 1'b0; step = 1'b0; halt_req = 1'b0; stall = 1'b0;
    @(negedge clock);
    #2 reset = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_pc", 32'(phasecounter), 32'h0);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_count", 32'(instr_count), 32'h0);
    @(negedge clock);
    #2 reset = 1'b0;

    // Run start with exec held three cycles: no second start, no pause.
    cpc(1, 0, 0, 0, 5'h00, "run_lat0");
    chk("run_running", 32'(running), 32'h1);
    cpc(1, 0, 0, 0, 5'h01, "run_p1");
    cpc(1, 0, 0, 0, 5'h02, "run_p2");
    cpc(0, 0, 0, 0, 5'h04, "run_p3");
    cpc(0, 0, 0, 0, 5'h08, "run_p4");
    cpc(0, 0, 0, 0, 5'h10, "run_p5");
    chk("run_count1", 32'(instr_count), 32'h1);
    cpc(0, 0, 0, 0, 5'h01, "run_wrap");
    cpc(0, 0, 0, 0, 5'h02, "run_p2b");
    // Pause request during phase 04 completes the instruction first.
    cpc(1, 0, 0, 0, 5'h04, "pause_p3");
    cpc(0, 0, 0, 0, 5'h08, "pause_p4");
    cpc(0, 0, 0, 0, 5'h10, "pause_p5");
    chk("pause_running", 32'(running), 32'h0);
    chk("pause_count", 32'(instr_count), 32'h2);
    cpc(0, 0, 0, 0, 5'h00, "pause_idle");
    cpc(1, 0, 0, 0, 5'h00, "resume_lat");
    cpc(0, 0, 0, 0, 5'h01, "resume_p1");

    // Single step.
    do_reset();
    cpc(0, 1, 0, 0, 5'h00, "step_lat");
    cpc(0, 0, 0, 0, 5'h01, "step_p1");
    cpc(0, 0, 0, 0, 5'h02, "step_p2");
    cpc(0, 0, 0, 0, 5'h04, "step_p3");
    cpc(0, 0, 0, 0, 5'h08, "step_p4");
    cpc(0, 0, 0, 0, 5'h10, "step_p5");
    chk("step_running", 32'(running), 32'h0);
    cpc(0, 0, 0, 0, 5'h00, "step_idle1");
    cpc(0, 0, 0, 0, 5'h00, "step_idle2");
    chk("step_count", 32'(instr_count), 32'h1);

    // Two-cycle stall at ptr=2.
    do_reset();
    cpc(1, 0, 0, 0, 5'h00, "stl_lat");
    cpc(0, 0, 0, 0, 5'h01, "stl_p1");
    cpc(0, 0, 0, 0, 5'h02, "stl_p2");
    cpc(0, 0, 0, 1, 5'h00, "stl_z1");
    cpc(0, 0, 0, 1, 5'h00, "stl_z2");
    cpc(0, 0, 0, 0, 5'h04, "stl_p3");
    cpc(0, 0, 0, 0, 5'h08, "stl_p4");
    chk("stl_count0", 32'(instr_count), 32'h0);
    cpc(0, 0, 0, 0, 5'h10, "stl_p5");
    chk("stl_count1", 32'(instr_count), 32'h1);

    // Halt requested during phase 01.
    do_reset();
    cpc(1, 0, 0, 0, 5'h00, "hlt_lat");
    cpc(0, 0, 1, 0, 5'h01, "hlt_p1");
    cpc(0, 0, 0, 0, 5'h02, "hlt_p2");
    cpc(0, 0, 0, 0, 5'h04, "hlt_p3");
    cpc(0, 0, 0, 0, 5'h08, "hlt_p4");
    cpc(0, 0, 0, 0, 5'h10, "hlt_p5");
    chk("hlt_halted", 32'(halted), 32'h1);
    chk("hlt_count", 32'(instr_count), 32'h1);
    cpc(1, 0, 0, 0, 5'h00, "hlt_exec_ign");
    cpc(0, 1, 0, 1, 5'h00, "hlt_step_ign");
    cpc(0, 0, 0, 0, 5'h00, "hlt_stay");
    chk("hlt_still", 32'(halted), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("hlt_rst_halted", 32'(halted), 32'h0);
    chk("hlt_rst_count", 32'(instr_count), 32'h0);
    @(negedge clock);
    #2 reset = 1'b0;

    // Exec and halt_req both at the boundary: halt wins.
    cpc(1, 0, 0, 0, 5'h00, "eh_lat");
    cpc(0, 0, 0, 0, 5'h01, "eh_p1");
    cpc(0, 0, 0, 0, 5'h02, "eh_p2");
    cpc(0, 0, 0, 0, 5'h04, "eh_p3");
    cpc(0, 0, 0, 0, 5'h08, "eh_p4");
    cpc(1, 0, 1, 0, 5'h10, "eh_p5");
    chk("eh_halted", 32'(halted), 32'h1);

    // Exec and step rising together: free run, not a single step.
    do_reset();
    cpc(1, 1, 0, 0, 5'h00, "es_lat");
    cpc(0, 0, 0, 0, 5'h01, "es_p1");
    cpc(0, 0, 0, 0, 5'h02, "es_p2");
    cpc(0, 0, 0, 0, 5'h04, "es_p3");
    cpc(0, 0, 0, 0, 5'h08, "es_p4");
    cpc(0, 0, 0, 0, 5'h10, "es_p5");
    cpc(0, 0, 0, 0, 5'h01, "es_wrap");
    chk("es_running", 32'(running), 32'h1);

    // Asynchronous reset while phase 04 is showing.
    cpc(0, 0, 0, 0, 5'h02, "ar_p2");
    cpc(0, 0, 0, 0, 5'h04, "ar_p3");
    #2 reset = 1'b1;
    #1;
    chk("ar_pc", 32'(phasecounter), 32'h0);
    chk("ar_running", 32'(running), 32'h0);
    @(negedge clock);
    #2 reset = 1'b0;

    // Random traffic, checked every cycle by the compare process.
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 249) do_reset();
      cyc(($urandom % 8) == 0, ($urandom % 8) == 0,
          ($urandom % 48) == 0, ($urandom % 4) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Generates the one-hot `phasecounter` bus that every pipeline register consumes; each register loads on its own bit (e.g. bit 1 for the ID/EX register).
- Produces the timing side of that interface: run/pause control, single-step, halt on a decoded HLT, and stall insertion.
- Counts completed instructions for the LED/debug display.
- Sits at the CPU top level, between the debounced board buttons and all pipeline registers.

Parameters:
- NPHASE, 5, number of phases per instruction; width of `phasecounter`.
- CNT_W, 16, width of `instr_count`.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- exec  in  1  debounced run/pause button, level; the block edge-detects it internally
- step  in  1  debounced single-step button, level; the block edge-detects it internally
- halt_req  in  1  pulse from decode when HLT is recognised
- stall  in  1  hazard stall; suppresses the current phase for one cycle
- phasecounter  out  NPHASE  registered one-hot phase strobe; all zero when idle, stalled or halted
- running  out  1  high in the RUN and STEP states
- halted  out  1  high in the HALTED state
- instr_count  out  CNT_W  number of completed instructions

Behaviour:
- Reset (asynchronous, reset=1): state=IDLE, `phasecounter`=0, internal pointer ptr=0, `instr_count`=0, halt_pend=0, pause_pend=0, exec_d=0, step_d=0; `running`=0, `halted`=0.
- Edge detection:
  - exec_rise = exec & ~exec_d; step_rise = step & ~step_d.
  - exec_d and step_d are registered every clock.
- States: IDLE, RUN, STEP, HALTED. `running` and `halted` are decoded from state.
- IDLE:
  - `phasecounter`<=0.
  - exec_rise -> RUN.
  - Otherwise step_rise -> STEP.
  - exec_rise wins when both rise in the same cycle.
- RUN / STEP, each clock:
  - stall=1: `phasecounter`<=0; ptr holds.
  - stall=0: `phasecounter`<=onehot(ptr); ptr<=ptr+1, wrapping from NPHASE-1 to 0.
  - halt_req=1 sets halt_pend.
  - exec_rise sets pause_pend (RUN only; ignored in STEP).
  - step_rise is ignored.
- Boundary = a clock with stall=0 and ptr=NPHASE-1, i.e. the last phase is issued on that edge. At a boundary:
  - `instr_count`<=`instr_count`+1, wrapping mod 2^CNT_W.
  - Next state by priority:
    1. halt_pend, or halt_req in that same cycle -> HALTED;
    2. otherwise pause_pend, exec_rise in that cycle, or state==STEP -> IDLE;
    3. otherwise stay.
  - Clear halt_pend and pause_pend.
- Phase 4 is always high for exactly one cycle before leaving RUN/STEP; `phasecounter` is 0 from the next cycle on.
- The block never leaves mid-instruction: ptr is always 0 in IDLE and HALTED.
- Latency: exec_rise sampled at edge k -> state RUN after k -> `phasecounter`=00001 after edge k+1.
- Unstalled RUN gives the sequence 00001,00010,00100,01000,10000,00001,… with one phase per clock and 5 clocks per instruction.
- HALTED: `phasecounter`=0. exec, step and stall are ignored. Only reset exits.
- A stall in IDLE or HALTED has no effect. A stall held for N cycles adds exactly N zero cycles and no phase is skipped.
- Reset asserted mid-instruction forces IDLE and `phasecounter`=0 immediately (asynchronously).

Test Plan:
- Reset, then pulse exec for 3 cycles, no stall -> `phasecounter` 0,0 then 01,02,04,08,10,01 (hex) repeating; `instr_count` increments every 5 cycles; `running`=1. Holding exec high produces no second start.
- In IDLE, pulse step -> exactly 01,02,04,08,10, then 0 forever; `instr_count`=1; state IDLE; `running`=0 after the boundary.
- RUN, stall=1 for 2 cycles while ptr=2 -> output 01,02,00,00,04,08,10; the instruction takes 7 cycles; count +1.
- RUN, halt_req pulse during phase 01 -> phases continue to 10, then 0; `halted`=1; `instr_count`+1. Later exec/step pulses have no effect; reset returns to IDLE with count 0.
- RUN, exec pulse during phase 04 -> completes 08,10, then IDLE. Another exec -> resumes at 01.
- Exec and halt_req at the same boundary -> HALTED. Exec and step rising together in IDLE -> RUN. Reset asserted at phase 04 -> `phasecounter`=0 without waiting for a clock edge.
